// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO result registers for the EX stage.
// One operation is accepted per start pulse while idle. MTHI/MTLO write
// immediately. Multiplies and divides compute their result at issue into
// pending registers, hold busy for a per-class latency, then commit to
// HI/LO. A cancel kills the in-flight operation without touching HI/LO.
module muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
   localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Full-width signed product of two WIDTH-bit operands.
   function automatic logic [2*WIDTH-1:0] mul_signed(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] ax;
      logic signed [2*WIDTH-1:0] bx;
      ax = signed'({{WIDTH{a[WIDTH-1]}}, a});
      bx = signed'({{WIDTH{b[WIDTH-1]}}, b});
      return ax * bx;
   endfunction

   // Full-width unsigned product of two WIDTH-bit operands.
   function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] ax;
      logic [2*WIDTH-1:0] bx;
      ax = {{WIDTH{1'b0}}, a};
      bx = {{WIDTH{1'b0}}, b};
      return ax * bx;
   endfunction

   // Signed divide via magnitudes, returns {remainder, quotient}. Working on
   // magnitudes makes most-negative / -1 wrap to most-negative with a zero
   // remainder instead of overflowing. A zero divisor yields zeros; the
   // caller never commits that case.
   function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] ua;
      logic [WIDTH-1:0] ub;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      ua = a[WIDTH-1] ? -a : a;
      ub = b[WIDTH-1] ? -b : b;
      if (ub == '0) begin
         q = '0;
         r = '0;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      if (a[WIDTH-1] ^ b[WIDTH-1]) q = -q;
      if (a[WIDTH-1]) r = -r;
      return {r, q};
   endfunction

   // Unsigned divide, returns {remainder, quotient}; zero divisor yields zeros.
   function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
      if (b == '0) return '0;
      return {a % b, a / b};
   endfunction

   state_e                   state;
   state_e                   state_nxt;
   logic [CW-1:0]            count;
   logic [CW-1:0]            count_nxt;
   logic [WIDTH-1:0]         hi_nxt;
   logic [WIDTH-1:0]         lo_nxt;
   logic [WIDTH-1:0]         pend_hi;
   logic [WIDTH-1:0]         pend_hi_nxt;
   logic [WIDTH-1:0]         pend_lo;
   logic [WIDTH-1:0]         pend_lo_nxt;

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic        [2*WIDTH-1:0] madd_res;
   logic        [2*WIDTH-1:0] msub_res;
   logic        [2*WIDTH-1:0] divs_res;
   logic        [2*WIDTH-1:0] divu_res;
   logic                      rt_zero;

   assign prod_s   = mul_signed(rs, rt);
   assign prod_u   = mul_unsigned(rs, rt);
   assign madd_res = {hi, lo} + prod_s;
   assign msub_res = {hi, lo} - prod_s;
   assign divs_res = div_signed(rs, rt);
   assign divu_res = div_unsigned(rs, rt);
   assign rt_zero  = (rt == '0);

   assign busy = (state == RUN);

   // State, countdown, pending results and HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
      end
   end

   // Issue, countdown, commit and cancel decisions.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      hi_nxt      = hi;
      lo_nxt      = lo;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      case (state)
         IDLE: begin
            if (start && !cancel) begin
               case (op)
                  OP_MTHI: hi_nxt = rs;
                  OP_MTLO: lo_nxt = rs;
                  OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                     case (op)
                        OP_MULT:  {pend_hi_nxt, pend_lo_nxt} = prod_s;
                        OP_MULTU: {pend_hi_nxt, pend_lo_nxt} = prod_u;
                        OP_MADD:  {pend_hi_nxt, pend_lo_nxt} = madd_res;
                        default:  {pend_hi_nxt, pend_lo_nxt} = msub_res;
                     endcase
                     count_nxt = MUL_CNT;
                     state_nxt = RUN;
                  end
                  default: begin
                     // Divide by zero still spends the full latency but
                     // recommits the current HI/LO, so nothing changes.
                     if (rt_zero)
                        {pend_hi_nxt, pend_lo_nxt} = {hi, lo};
                     else if (op == OP_DIV)
                        {pend_hi_nxt, pend_lo_nxt} = divs_res;
                     else
                        {pend_hi_nxt, pend_lo_nxt} = divu_res;
                     count_nxt = DIV_CNT;
                     state_nxt = RUN;
                  end
               endcase
            end
         end
         RUN: begin
            if (cancel) begin
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (count == CNT_ONE) begin
               hi_nxt    = pend_hi;
               lo_nxt    = pend_lo;
               count_nxt = '0;
               state_nxt = IDLE;
            end else begin
               count_nxt = count - CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// A timeline model computes results with 64-bit integer arithmetic and
// schedules their commit by absolute edge count; a negedge process compares
// busy/hi/lo against it every cycle. Directed vectors add literal checks.
module tb_muldiv_unit;

   localparam int LAT_MUL = 5;
   localparam int LAT_DIV = 10;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        start  = 1'b0;
   logic        cancel = 1'b0;
   logic [2:0]  op     = 3'd0;
   logic [31:0] rs     = 32'd0;
   logic [31:0] rt     = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   int n;

   muldiv_unit #(.WIDTH(32), .MUL_LAT(LAT_MUL), .DIV_LAT(LAT_DIV)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs     (rs),
      .rt     (rt),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint      edge_no   = 0;
   longint      commit_at = 0;
   bit          pending   = 1'b0;
   logic [31:0] m_hi      = 32'd0;
   logic [31:0] m_lo      = 32'd0;
   logic [63:0] m_result  = 64'd0;

   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] acc;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      acc = {h, l};
      p   = 64'(sa * sb);
      case (o)
         3'd0: return p;
         3'd1: return {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0) return {h, l};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 32'd0) return {h, l};
            return {a % b, a / b};
         end
         3'd4: return acc + p;
         default: return acc - p;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pending = 1'b0;
         m_hi    = 32'd0;
         m_lo    = 32'd0;
      end else begin
         edge_no++;
         if (pending) begin
            if (cancel) begin
               pending = 1'b0;
            end else if (edge_no == commit_at) begin
               {m_hi, m_lo} = m_result;
               pending      = 1'b0;
            end
         end else if (start && !cancel) begin
            if (op == 3'd6) m_hi = rs;
            else if (op == 3'd7) m_lo = rs;
            else begin
               m_result  = ref_result(op, rs, rt, m_hi, m_lo);
               commit_at = edge_no + ((op == 3'd2 || op == 3'd3) ? LAT_DIV : LAT_MUL);
               pending   = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cyc_busy", 64'(busy), 64'(pending));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
   end

   // Issue one operation and count the cycles busy stays high.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cnt);
      @(negedge clk);
      start = 1'b1; op = o; rs = a; rt = b;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic chk_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
      chk({name, "_hi"}, 64'(hi), 64'(eh));
      chk({name, "_lo"}, 64'(lo), 64'(el));
      chk({name, "_model"}, {m_hi, m_lo}, {eh, el});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk_hl("reset", 32'd0, 32'd0);
      reset = 1'b0;

      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, n);
      chk("mult_busy_cycles", 64'(n), 64'd5);
      chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_busy_cycles", 64'(n), 64'd10);
      chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(3'd3, 32'd7, 32'd0, n);
      chk("divu0_busy_cycles", 64'(n), 64'd10);
      chk_hl("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
      chk_hl("div_minneg", 32'd0, 32'h8000_0000);

      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
      chk_hl("div_negdivisor", 32'd1, 32'hFFFF_FFFD);

      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
      chk_hl("divu", 32'd1, 32'h7FFF_FFFC);

      run_op(3'd6, 32'd1, 32'd0, n);
      chk("mthi_busy_cycles", 64'(n), 64'd0);
      run_op(3'd7, 32'hFFFF_FFFF, 32'd0, n);
      chk_hl("mtlo", 32'd1, 32'hFFFF_FFFF);

      run_op(3'd4, 32'd1, 32'd1, n);
      chk("madd_busy_cycles", 64'(n), 64'd5);
      chk_hl("madd", 32'd2, 32'd0);
      run_op(3'd5, 32'd2, 32'd1, n);
      chk_hl("msub", 32'd1, 32'hFFFF_FFFE);

      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, n);
      chk_hl("mult_minmin", 32'h4000_0000, 32'd0);

      // MULTU with a DIV start pulsed on busy cycle 2: the DIV is ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd1; rs = 32'h0001_0000; rt = 32'h0003_0000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n = 2;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("multu_busy_cycles", 64'(n), 64'd5);
      chk_hl("multu", 32'd3, 32'd0);
      @(negedge clk);
      chk("ignored_div_busy", 64'(busy), 64'd0);

      // DIV cancelled on busy cycle 4.
      start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_cancel_busy", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      chk_hl("cancel", 32'd3, 32'd0);
      repeat (12) @(negedge clk);
      chk_hl("cancel_late", 32'd3, 32'd0);

      // start together with cancel: nothing issues.
      start = 1'b1; cancel = 1'b1; op = 3'd7; rs = 32'hDEAD_BEEF;
      @(negedge clk);
      op = 3'd0; rs = 32'd9; rt = 32'd9;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("startcancel_busy", 64'(busy), 64'd0);
      chk_hl("startcancel", 32'd3, 32'd0);

      // Asynchronous reset between edges during a MULT.
      start = 1'b1; op = 3'd0; rs = 32'd11; rt = 32'd13;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk_hl("async_reset", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op(3'd0, 32'd5, 32'd6, n);
      chk("post_reset_busy_cycles", 64'(n), 64'd5);
      chk_hl("post_reset_mult", 32'd0, 32'd30);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multiply/divide unit with HI/LO result registers, sitting in the EX stage beside the ALU. Accepts one operation per `start` pulse, holds `busy` for a programmable per-class latency, then commits to HI/LO. Generalises the fixed 32-bit unit with:
- configurable width and latencies;
- multiply-accumulate (MADD/MSUB);
- an unsigned divide-by-zero rule;
- a `cancel` input so the exception path can kill an in-flight operation.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `MUL_LAT`, 5, busy cycles for MULT/MULTU/MADD/MSUB; must be ≥1.
- `DIV_LAT`, 10, busy cycles for DIV/DIVU; must be ≥1.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: issue strobe, sampled on the rising edge.
- `op` input 3: operation code, sampled with `start`. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- `rs` input WIDTH: operand A; also the MTHI/MTLO source.
- `rt` input WIDTH: operand B.
- `cancel` input 1: abort the in-flight operation and suppress any same-cycle `start`.
- `busy` output 1: an operation is in flight.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
Reset values:
- `hi`, `lo` = 0.
- `busy` = 0.
- internal countdown = 0.
- pending-result registers = 0.

States:
- IDLE (countdown 0, `busy`=0).
- RUN (countdown >0, `busy`=1).

Issue rules:
- Issue occurs when `start`=1, `busy`=0 and `cancel`=0.
- `start` while `busy`=1 is ignored; no state changes. The hazard unit is expected never to do this, but RTL must tolerate it.

MTHI/MTLO:
- Write `rs` into `hi`/`lo` at the issuing edge.
- `busy` stays 0.

Multiply and divide:
- On issue, the result is computed from `rs`, `rt`, `hi` and `lo` as sampled at that edge and latched into pending registers.
- The countdown is loaded with MUL_LAT or DIV_LAT and the unit enters RUN.
- The countdown decrements each edge while in RUN. On the edge where it goes 1→0, pending results are copied to `hi`/`lo` and the unit returns to IDLE.

Arithmetic (all results modulo 2^WIDTH per register):
- MULT/MULTU: the signed/unsigned 2·WIDTH-bit product; `hi` gets the upper half, `lo` the lower half.
- MADD/MSUB: {hi,lo} ± signed(rs)·signed(rt), modulo 2^(2·WIDTH), using `hi`/`lo` values at issue.
- DIV: `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - Most-negative ÷ −1 gives `lo` = most-negative, `hi` = 0.
- DIVU: unsigned quotient to `lo`, remainder to `hi`.
- Divide by zero (DIV or DIVU): the operation runs the full DIV_LAT cycles with `busy` high, then leaves `hi`/`lo` unchanged.

Cancel:
- `cancel`=1 at an edge while in RUN clears the countdown, discards pending results (`hi`/`lo` unchanged) and returns to IDLE.
- `cancel` with `start` in IDLE: nothing issues, MTHI/MTLO included.

## Timing
- Issue edge E0 (operation sampled). `busy`=1 from just after E0 through the edge E0+LAT.
- `hi`/`lo` show the new values and `busy`=0 immediately after edge E0+LAT.
- Back-to-back issue is allowed at edge E0+LAT+1 at the earliest, since `start` is only honoured when `busy`=0 before the edge.
- MTHI/MTLO: zero-latency, visible after the issuing edge.
- `busy`, `hi` and `lo` are registered outputs with no combinational path from inputs.
- `reset` asserted mid-RUN: `busy` drops and `hi`/`lo` clear asynchronously, with no commit.
- Countdown width is clog2(max(MUL_LAT, DIV_LAT)+1).

## Test plan
- Reset, then MULT rs=−3 (0xFFFFFFFD), rt=7 with WIDTH=32, MUL_LAT=5 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=−7, rt=2 (DIV_LAT=10) → `busy` 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then DIVU 7/0 → hi/lo unchanged after 10 cycles.
- MTHI 0x1, MTLO 0xFFFFFFFF, then MADD rs=1, rt=1 → {hi,lo}=0x0000_0002_0000_0000. Then MSUB rs=2, rt=1 → {hi,lo}=0x0000_0001_FFFF_FFFE.
- MULTU issued, `start` with a DIV pulsed on cycle 2 of `busy` → DIV ignored; MULTU result committed at the normal edge.
- DIV issued, `cancel` on busy cycle 4 → `busy` drops the next cycle; hi/lo keep their prior values. Also `start`+`cancel` together with MTLO → `lo` unchanged.
- Async `reset` pulse mid-MULT (between edges) → busy=0 and hi=lo=0 immediately; a new MULT issues normally afterwards.
